// File: rtl/pkt_encoder_gen_if.sv
// Packet encoder bus: packet offer handshake plus the serial bit stream.
// The master side offers packets and watches the stream; the slave is the encoder.
interface pkt_encoder_gen_if #(
    parameter int MAX_BITS = 99
);
    localparam int LEN_W = $clog2(MAX_BITS + 1);

    logic [MAX_BITS-1:0] pkt;
    logic [LEN_W-1:0]    pkt_len;
    logic [1:0]          crc_mode;
    logic                pkt_valid;
    logic                pkt_ready;
    logic                bstr;
    logic                bstr_valid;
    logic                bstr_eop;
    logic                pkt_sent;

    modport master (
        output pkt, pkt_len, crc_mode, pkt_valid,
        input  pkt_ready, bstr, bstr_valid, bstr_eop, pkt_sent
    );

    modport slave (
        input  pkt, pkt_len, crc_mode, pkt_valid,
        output pkt_ready, bstr, bstr_valid, bstr_eop, pkt_sent
    );
endinterface

// File: rtl/pkt_encoder_gen.sv
// Serial packet encoder: sends a left-aligned packet MSB-first, optionally
// appends a complemented CRC5/CRC16 over the post-header bits, inserts a
// zero stuff bit after every six consecutive ones, and closes with an EOP.
module pkt_encoder_gen #(
    parameter int MAX_BITS   = 99,
    parameter int HDR_BITS   = 16,
    parameter int EOP_CYCLES = 3,
    parameter int STUFF_EN   = 1
) (
    input  logic               clk,
    input  logic               rst_b,
    pkt_encoder_gen_if.slave   bus
);
    localparam int CNT_W = $clog2(MAX_BITS + 1);
    localparam int EOP_W = (EOP_CYCLES > 1) ? $clog2(EOP_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, DATA, CRC, EOP} state_t;

    state_t              state;
    state_t              next_state;

    logic [MAX_BITS-1:0] pkt_sr;
    logic [CNT_W-1:0]    len_reg;
    logic [1:0]          mode_reg;
    logic [CNT_W-1:0]    bit_cnt;
    logic [15:0]         crc_reg;
    logic [4:0]          crc_cnt;
    logic [2:0]          ones_cnt;
    logic [EOP_W-1:0]    eop_cnt;
    logic                sent_flag;

    logic                accept;
    logic                stuff_now;
    logic                cur_bit;
    logic                emit_bit;
    logic [2:0]          ones_next;
    logic                crc_on;
    logic [4:0]          crc_len;
    logic                eop_last;
    logic [CNT_W-1:0]    len_clamped;
    logic [15:0]         crc_next;
    logic                bstr_o;
    logic                valid_o;
    logic                eop_o;

    assign crc_on      = (mode_reg == 2'd1) || (mode_reg == 2'd2);
    assign crc_len     = (mode_reg == 2'd1) ? 5'd5 : 5'd16;
    assign eop_last    = (eop_cnt == EOP_W'(EOP_CYCLES - 1));
    assign stuff_now   = (STUFF_EN != 0) && (ones_cnt == 3'd6);
    assign len_clamped = (32'(bus.pkt_len) > MAX_BITS) ? CNT_W'(MAX_BITS) : bus.pkt_len;

    assign bus.pkt_ready  = (state == IDLE);
    assign bus.pkt_sent   = (state == IDLE) && sent_flag;
    assign bus.bstr       = bstr_o;
    assign bus.bstr_valid = valid_o;
    assign bus.bstr_eop   = eop_o;

    // Next CRC value if the current bit is folded in (CRC5 lives in bits [4:0]).
    always_comb begin
        crc_next = crc_reg;
        if (mode_reg == 2'd1) begin
            crc_next = {11'd0, crc_reg[3:0], 1'b0} ^
                       ((crc_reg[4] ^ cur_bit) ? 16'h0005 : 16'h0000);
        end else begin
            crc_next = {crc_reg[14:0], 1'b0} ^
                       ((crc_reg[15] ^ cur_bit) ? 16'h8005 : 16'h0000);
        end
    end

    // Next-state and stream outputs; a stuff cycle holds the bit source still.
    always_comb begin
        next_state = state;
        accept     = 1'b0;
        emit_bit   = 1'b0;
        cur_bit    = 1'b0;
        ones_next  = ones_cnt;
        bstr_o     = 1'b0;
        valid_o    = 1'b0;
        eop_o      = 1'b0;
        case (state)
            IDLE: begin
                if (bus.pkt_valid) begin
                    accept     = 1'b1;
                    next_state = (bus.pkt_len == '0) ? EOP : DATA;
                end
            end
            DATA: begin
                valid_o = 1'b1;
                if (stuff_now) begin
                    ones_next = 3'd0;
                    if (bit_cnt == len_reg) begin
                        next_state = crc_on ? CRC : EOP;
                    end
                end else begin
                    cur_bit   = pkt_sr[MAX_BITS-1];
                    emit_bit  = 1'b1;
                    bstr_o    = cur_bit;
                    ones_next = cur_bit ? (ones_cnt + 3'd1) : 3'd0;
                    if (((bit_cnt + CNT_W'(1)) == len_reg) &&
                        !((STUFF_EN != 0) && (ones_next == 3'd6))) begin
                        next_state = crc_on ? CRC : EOP;
                    end
                end
            end
            CRC: begin
                valid_o = 1'b1;
                if (stuff_now) begin
                    ones_next = 3'd0;
                    if (crc_cnt == crc_len) begin
                        next_state = EOP;
                    end
                end else begin
                    cur_bit   = (mode_reg == 2'd1) ? ~crc_reg[4] : ~crc_reg[15];
                    emit_bit  = 1'b1;
                    bstr_o    = cur_bit;
                    ones_next = cur_bit ? (ones_cnt + 3'd1) : 3'd0;
                    if (((crc_cnt + 5'd1) == crc_len) &&
                        !((STUFF_EN != 0) && (ones_next == 3'd6))) begin
                        next_state = EOP;
                    end
                end
            end
            EOP: begin
                eop_o = 1'b1;
                if (eop_last) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Packet latch, bit/CRC/ones counters, EOP timer and completion flag.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            pkt_sr    <= '0;
            len_reg   <= '0;
            mode_reg  <= 2'd0;
            bit_cnt   <= '0;
            crc_reg   <= '0;
            crc_cnt   <= 5'd0;
            ones_cnt  <= 3'd0;
            eop_cnt   <= '0;
            sent_flag <= 1'b0;
        end else begin
            sent_flag <= (state == EOP) && eop_last;
            eop_cnt   <= (state == EOP) ? (eop_cnt + EOP_W'(1)) : '0;
            if (accept) begin
                pkt_sr   <= bus.pkt;
                len_reg  <= len_clamped;
                mode_reg <= bus.crc_mode;
                bit_cnt  <= '0;
                crc_reg  <= 16'hFFFF;
                crc_cnt  <= 5'd0;
                ones_cnt <= 3'd0;
            end else begin
                if ((state == DATA) || (state == CRC)) begin
                    ones_cnt <= ones_next;
                end
                if ((state == DATA) && emit_bit) begin
                    pkt_sr <= {pkt_sr[MAX_BITS-2:0], 1'b0};
                    if (bit_cnt < len_reg) begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                    if (32'(bit_cnt) >= HDR_BITS) begin
                        crc_reg <= crc_next;
                    end
                end
                if ((state == CRC) && emit_bit) begin
                    crc_reg <= {crc_reg[14:0], 1'b0};
                    crc_cnt <= crc_cnt + 5'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_pkt_encoder_gen.sv
// Testbench for pkt_encoder_gen: directed packets with literal expected
// streams plus randomized packets checked against a bit-list reference model.
module tb_pkt_encoder_gen;
    localparam int MAX_BITS   = 99;
    localparam int HDR_BITS   = 16;
    localparam int EOP_CYCLES = 3;
    localparam int LEN_W      = $clog2(MAX_BITS + 1);

    typedef logic [4:0] obs_t;

    logic clk;
    logic rst_b;
    int   errors = 0;
    int   checks = 0;
    obs_t exp_q[$];

    pkt_encoder_gen_if #(.MAX_BITS(MAX_BITS)) bus ();

    pkt_encoder_gen #(
        .MAX_BITS(MAX_BITS), .HDR_BITS(HDR_BITS),
        .EOP_CYCLES(EOP_CYCLES), .STUFF_EN(1)
    ) dut (
        .clk(clk),
        .rst_b(rst_b),
        .bus(bus.slave)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observation vector {ready, valid, bstr, eop, sent}.
    function automatic obs_t observe();
        return {bus.pkt_ready, bus.bstr_valid, bus.bstr, bus.bstr_eop, bus.pkt_sent};
    endfunction

    function automatic logic [MAX_BITS-1:0] rand_pkt(input bit dense);
        logic [MAX_BITS-1:0] r;
        for (int i = 0; i < MAX_BITS; i++) begin
            r[i] = dense ? ($urandom_range(0, 7) != 0) : 1'($urandom_range(0, 1));
        end
        return r;
    endfunction

    // Push raw bits MSB-first as valid stream cycles (no stuffing applied).
    task automatic push_bits(input logic [127:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            exp_q.push_back({2'b01, v[i], 2'b00});
        end
    endtask

    // EOP cycles followed by the completion cycle.
    task automatic push_tail();
        for (int i = 0; i < EOP_CYCLES; i++) exp_q.push_back(5'b00010);
        exp_q.push_back(5'b10001);
    endtask

    // Reference model: bit list -> append complemented CRC -> stuff -> EOP.
    task automatic model_packet(input logic [MAX_BITS-1:0] p, input int len, input int mode);
        bit raw[$];
        int n = (len > MAX_BITS) ? MAX_BITS : len;
        int ones = 0;
        if (n > 0) begin
            for (int i = 0; i < n; i++) raw.push_back(p[MAX_BITS-1-i]);
            if (mode == 1 || mode == 2) begin
                int w    = (mode == 1) ? 5 : 16;
                int poly = (mode == 1) ? 'h05 : 'h8005;
                int mask = (1 << w) - 1;
                int crc  = mask;
                for (int i = HDR_BITS; i < n; i++) begin
                    int fb = ((crc >> (w - 1)) & 1) ^ int'(raw[i]);
                    crc = (crc << 1) & mask;
                    if (fb != 0) crc = crc ^ poly;
                end
                for (int k = w - 1; k >= 0; k--) raw.push_back(((crc >> k) & 1) == 0);
            end
            foreach (raw[i]) begin
                exp_q.push_back({2'b01, raw[i], 2'b00});
                ones = raw[i] ? ones + 1 : 0;
                if (ones == 6) begin
                    exp_q.push_back(5'b01000);
                    ones = 0;
                end
            end
        end
        push_tail();
    endtask

    // Offer a packet at a falling edge once ready; optionally keep pkt_valid high.
    task automatic accept_packet(input logic [MAX_BITS-1:0] p, input int len,
                                 input int mode, input bit hold);
        int waited = 0;
        @(negedge clk);
        while (!bus.pkt_ready && waited < 500) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 500) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout: pkt_ready got 0 required 1");
        end
        bus.pkt       = p;
        bus.pkt_len   = LEN_W'(len);
        bus.crc_mode  = 2'(mode);
        bus.pkt_valid = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) begin
            bus.pkt_valid = 1'b0;
            bus.pkt       = rand_pkt(0);
            bus.pkt_len   = LEN_W'($urandom);
            bus.crc_mode  = 2'($urandom);
        end
    endtask

    // Compare the stream cycle by cycle against the expected queue.
    task automatic check_stream(input string name, input int limit);
        int   n = 0;
        obs_t e;
        obs_t o;
        while (exp_q.size() > 0 && (limit < 0 || n < limit)) begin
            e = exp_q.pop_front();
            @(negedge clk);
            o = observe();
            checks++;
            if (o !== e) begin
                errors++;
                $display("[TB] FAIL %s cycle %0d: got %b required %b", name, n + 1, o, e);
            end
            n++;
        end
    endtask

    task automatic test_reset();
        obs_t o;
        #3;
        o = observe();
        checks++;
        if (o !== 5'b10000) begin
            errors++;
            $display("[TB] FAIL reset_state: got %b required %b", o, 5'b10000);
        end
        repeat (3) @(negedge clk);
        rst_b = 1'b1;
        @(negedge clk);
        o = observe();
        checks++;
        if (o !== 5'b10000) begin
            errors++;
            $display("[TB] FAIL post_reset_idle: got %b required %b", o, 5'b10000);
        end
    endtask

    task automatic test_handshake();
        accept_packet({16'h01D2, 83'd0}, 16, 0, 0);
        push_bits(128'h01D2, 16);
        push_tail();
        check_stream("handshake", -1);
    endtask

    task automatic test_crc5_token();
        accept_packet({8'h01, 8'hE1, 11'd0, 72'd0}, 27, 1, 0);
        push_bits({101'd0, 8'h01, 8'hE1, 11'd0}, 27);
        push_bits(128'b01000, 5);
        push_tail();
        check_stream("crc5_token", -1);
    endtask

    task automatic test_stuffing();
        accept_packet({16'hFFFF, 83'd0}, 16, 0, 0);
        push_bits(128'b111111011111101111, 18);
        push_tail();
        check_stream("stuffing", -1);
    endtask

    task automatic test_length_limits();
        logic [MAX_BITS-1:0] p;
        accept_packet(rand_pkt(1), 0, 2, 0);
        push_tail();
        check_stream("len_zero", -1);
        accept_packet({MAX_BITS{1'b0}}, HDR_BITS, 2, 0);
        push_bits(128'd0, HDR_BITS + 16);
        push_tail();
        check_stream("hdr_only_crc16", -1);
        p = rand_pkt(1);
        model_packet(p, MAX_BITS + 5, 0);
        accept_packet(p, MAX_BITS + 5, 0, 0);
        check_stream("len_clamp", -1);
        p = rand_pkt(0);
        model_packet(p, MAX_BITS + 5, 2);
        accept_packet(p, MAX_BITS + 5, 2, 0);
        check_stream("len_clamp_crc16", -1);
    endtask

    task automatic test_back_to_back();
        logic [MAX_BITS-1:0] p1 = rand_pkt(1);
        logic [MAX_BITS-1:0] p2 = rand_pkt(0);
        model_packet(p1, 24, 1);
        accept_packet(p1, 24, 1, 1);
        bus.pkt      = p2;
        bus.pkt_len  = LEN_W'(30);
        bus.crc_mode = 2'd2;
        check_stream("b2b_first", -1);
        @(posedge clk);
        #1;
        bus.pkt_valid = 1'b0;
        model_packet(p2, 30, 2);
        check_stream("b2b_second", -1);
    endtask

    task automatic test_reset_mid_packet();
        logic [MAX_BITS-1:0] p = rand_pkt(1);
        obs_t o;
        model_packet(p, MAX_BITS, 2);
        accept_packet(p, MAX_BITS, 2, 0);
        check_stream("pre_reset", 40);
        exp_q.delete();
        #2;
        rst_b = 1'b0;
        #1;
        o = observe();
        checks++;
        if (o !== 5'b10000) begin
            errors++;
            $display("[TB] FAIL reset_mid_immediate: got %b required %b", o, 5'b10000);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 2) rst_b = 1'b1;
            o = observe();
            checks++;
            if (o !== 5'b10000) begin
                errors++;
                $display("[TB] FAIL reset_mid_hold%0d: got %b required %b", i, o, 5'b10000);
            end
        end
        p = rand_pkt(1);
        model_packet(p, 45, 2);
        accept_packet(p, 45, 2, 0);
        check_stream("post_reset_pkt", -1);
    endtask

    task automatic test_random();
        logic [MAX_BITS-1:0] p;
        int len;
        int mode;
        for (int t = 0; t < 24; t++) begin
            p    = rand_pkt(t[0]);
            len  = $urandom_range(0, MAX_BITS + 5);
            mode = $urandom_range(0, 3);
            model_packet(p, len, mode);
            accept_packet(p, len, mode, 0);
            check_stream($sformatf("random%0d", t), -1);
        end
    endtask

    // Scenario sequence and summary.
    initial begin
        rst_b         = 1'b0;
        bus.pkt       = '0;
        bus.pkt_len   = '0;
        bus.crc_mode  = 2'd0;
        bus.pkt_valid = 1'b0;
        test_reset();
        test_handshake();
        test_crc5_token();
        test_stuffing();
        test_length_limits();
        test_back_to_back();
        test_reset_mid_packet();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Hard time limit so the bench can never hang.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation still running at time limit");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule

// File: doc/pkt_encoder_gen.md
PKT_ENCODER_GEN -- requirements
Module: pkt_encoder_gen

Interface
REQ-001 SHALL have parameter MAX_BITS, default 99, giving the packet buffer width in bits.
REQ-002 SHALL have parameter HDR_BITS, default 16, giving the count of leading bits (SYNC+PID) excluded from CRC.
REQ-003 SHALL have parameter EOP_CYCLES, default 3, giving the EOP length in cycles.
REQ-004 SHALL have parameter STUFF_EN, default 1; when 1, bit stuffing is enabled.
REQ-005 clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 rst_b  input  1  asynchronous, active-low reset.
REQ-007 pkt  input  MAX_BITS  packet bits, left-aligned; the first bit sent is pkt[MAX_BITS-1].
REQ-008 pkt_len  input  $clog2(MAX_BITS+1)  number of packet bits to send, including header.
REQ-009 crc_mode  input  2  0 = none, 1 = CRC5, 2 = CRC16, 3 = treated as none.
REQ-010 pkt_valid  input  1  a packet is offered.
REQ-011 pkt_ready  output  1  the block can accept a packet.
REQ-012 bstr  output  1  serial bit.
REQ-013 bstr_valid  output  1  bstr carries a data, CRC or stuff bit this cycle.
REQ-014 bstr_eop  output  1  the cycle is an EOP cycle.
REQ-015 pkt_sent  output  1  one-cycle completion pulse.

Function
REQ-016 SHALL implement FSM states IDLE, DATA, CRC, EOP.
REQ-017 pkt_ready SHALL be 1 exactly when the state is IDLE.
REQ-018 Acceptance SHALL occur on a cycle with pkt_valid=1 and pkt_ready=1.
- On acceptance, pkt, pkt_len and crc_mode SHALL be registered.
- Inputs after acceptance SHALL be ignored until the next acceptance.
REQ-019 pkt_len > MAX_BITS SHALL be clamped to MAX_BITS.
REQ-020 pkt_len = 0 SHALL go IDLE->EOP directly: no data or CRC, crc_mode ignored.
REQ-021 Transitions from IDLE on acceptance:
- IDLE->DATA; the first bit appears on bstr with bstr_valid=1 in the cycle after acceptance.
- DATA emits registered bits MSB-first, one per non-stuff cycle, until pkt_len bits are sent.
- DATA->CRC if the latched mode is 1 or 2, else DATA->EOP.
REQ-022 CRC computation:
- Runs over data bits with index >= HDR_BITS in send order; stuff bits are excluded.
- CRC5 polynomial x^5+x^2+1; CRC16 polynomial x^16+x^15+x^2+1.
- Register initialised to all ones at acceptance.
- feedback = crc_msb XOR bit; shift left; XOR the polynomial when feedback = 1.
REQ-023 CRC SHALL emit the complemented CRC MSB-first: 5 or 16 bits, then CRC->EOP.
- If pkt_len <= HDR_BITS, the CRC sent is ~all-ones = all zeros.
REQ-024 Bit stuffing (STUFF_EN=1):
- A ones counter tracks consecutive 1s on valid bits across DATA and CRC; it is cleared at acceptance.
- After the 6th consecutive 1, the next cycle emits bstr=0, bstr_valid=1 as a stuff bit.
- The bit source does not advance during a stuff bit.
- The counter clears on any 0 or stuff bit.
- A stuff bit due after the final CRC or data bit SHALL be emitted before EOP.
REQ-025 With STUFF_EN=0, no stuff bits SHALL be emitted.
REQ-026 EOP SHALL last exactly EOP_CYCLES cycles with bstr=0, bstr_valid=0, bstr_eop=1, then EOP->IDLE.
REQ-027 pkt_sent SHALL be 1 for exactly the first cycle back in IDLE.
- A packet may be accepted in that same cycle (back-to-back, no dead cycle).
REQ-028 Outside DATA/CRC/EOP, bstr, bstr_valid and bstr_eop SHALL be 0.
REQ-029 Bit counter width SHALL be $clog2(MAX_BITS+1); it SHALL saturate at the clamped length and never wrap.

Reset
REQ-030 When rst_b=0, the block SHALL asynchronously enter IDLE, clearing the CRC register, bit counter and ones counter.
- Outputs during and after reset: pkt_ready=1, bstr=0, bstr_valid=0, bstr_eop=0, pkt_sent=0.
REQ-031 Reset mid-packet SHALL abort the packet with no pkt_sent pulse.
- The first post-reset acceptance SHALL behave as from power-up.

Verification
REQ-032 Handshake: pkt={0x01,0xD2}, pkt_len=16, crc_mode=0 -> 16 valid bits 00000001 11010010, then 3 EOP cycles, pkt_sent in cycle 20 after acceptance.
REQ-033 Token CRC5: pkt={0x01,0xE1,11 zero bits}, pkt_len=27, crc_mode=1 -> 27 data bits, then CRC bits 01000, then EOP.
REQ-034 Stuffing: 16 ones, crc_mode=0, STUFF_EN=1 -> 111111 0 111111 0 1111 (18 valid cycles), then 3 EOP cycles.
REQ-035 Back-to-back: pkt_valid held high with two packets -> second acceptance in the pkt_sent cycle, first bit of packet two the next cycle.
REQ-036 Reset at bit 40 of a CRC16 packet -> all outputs immediately 0 except pkt_ready=1, no pkt_sent; next packet correct.
REQ-037 pkt_len=0 and pkt_len=MAX_BITS+5:
- pkt_len=0 -> EOP only, pkt_sent 4 cycles after acceptance.
- pkt_len=MAX_BITS+5 -> exactly MAX_BITS data bits sent (plus stuff bits).
